// File: rtl/ldmx_reg_pkg.sv
// Shared address map, bus widths and handshake state encoding for the
// DPM strobe/acknowledge register responder.
package ldmx_reg_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] CTRL_BASE    = 8'h00;
    localparam logic [ADDR_W-1:0] STAT_BASE    = 8'h40;
    localparam logic [ADDR_W-1:0] PULSE_ADDR   = 8'h80;
    localparam logic [ADDR_W-1:0] WCNT_ADDR    = 8'hFC;
    localparam logic [ADDR_W-1:0] RCNT_ADDR    = 8'hFD;
    localparam logic [ADDR_W-1:0] SCRATCH_ADDR = 8'hFE;
    localparam logic [ADDR_W-1:0] ID_ADDR      = 8'hFF;

    localparam logic [DATA_W-1:0] UNMAPPED_VAL = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_ACK      = 2'd1,
        HS_WAIT_LOW = 2'd2
    } hs_state_t;

endpackage

// File: rtl/ldmx_reg_responder_if.sv
// Strobe/acknowledge register bus: independent write and read channels.
interface ldmx_reg_responder_if;
    import ldmx_reg_pkg::*;

    logic              axi_wstr;
    logic [ADDR_W-1:0] axi_waddr;
    logic [DATA_W-1:0] axi_din;
    logic              axi_wack;
    logic              axi_rstr;
    logic [ADDR_W-1:0] axi_raddr;
    logic [DATA_W-1:0] axi_dout;
    logic              axi_rack;

    modport master (
        output axi_wstr, axi_waddr, axi_din, axi_rstr, axi_raddr,
        input  axi_wack, axi_rack, axi_dout
    );

    modport slave (
        input  axi_wstr, axi_waddr, axi_din, axi_rstr, axi_raddr,
        output axi_wack, axi_rack, axi_dout
    );

endinterface

// File: rtl/ldmx_reg_hs.sv
// One strobe/acknowledge handshake: a level strobe yields a one-cycle
// capture followed by a one-cycle ack, then waits for the strobe to drop.
module ldmx_reg_hs
    import ldmx_reg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic capture,
    output logic ack
);

    hs_state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HS_IDLE;
            capture <= 1'b0;
            ack     <= 1'b0;
        end else begin
            capture <= 1'b0;
            ack     <= 1'b0;
            case (state)
                HS_IDLE: begin
                    if (strobe) begin
                        state   <= HS_ACK;
                        capture <= 1'b1;
                    end
                end
                HS_ACK: begin
                    state <= HS_WAIT_LOW;
                    ack   <= 1'b1;
                end
                // A strobe still held here belongs to the request just served.
                HS_WAIT_LOW: begin
                    if (!strobe) state <= HS_IDLE;
                end
                default: state <= HS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ldmx_reg_responder.sv
// Generic register responder: RW control bank, RO status bank, write-one
// pulse register, scratch, transaction counters and block ID.
module ldmx_reg_responder
    import ldmx_reg_pkg::*;
#(
    parameter int              N_CTRL   = 8,
    parameter int              N_STAT   = 8,
    parameter logic [31:0]     CTRL_RST = 32'h0,
    parameter logic [31:0]     BLOCK_ID = 32'h4C444D58
) (
    input  logic                     axi_clk,
    input  logic                     reset,
    ldmx_reg_responder_if.slave      bus,
    output logic [N_CTRL*DATA_W-1:0] ctrl_out,
    input  logic [N_STAT*DATA_W-1:0] stat_in,
    output logic [DATA_W-1:0]        pulse_out
);

    logic              wr_capture;
    logic              wr_ack;
    logic              rd_capture;
    logic              rd_ack;

    logic [ADDR_W-1:0] waddr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [ADDR_W-1:0] raddr_p0;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_data_p1;

    logic [DATA_W-1:0] ctrl_q [N_CTRL];
    logic [DATA_W-1:0] scratch_q;
    logic [DATA_W-1:0] wcnt_q;
    logic [DATA_W-1:0] rcnt_q;

    ldmx_reg_hs u_wr_hs (
        .clk     (axi_clk),
        .rst     (reset),
        .strobe  (bus.axi_wstr),
        .capture (wr_capture),
        .ack     (wr_ack)
    );

    ldmx_reg_hs u_rd_hs (
        .clk     (axi_clk),
        .rst     (reset),
        .strobe  (bus.axi_rstr),
        .capture (rd_capture),
        .ack     (rd_ack)
    );

    assign bus.axi_wack = wr_ack;

    // Stage p0: address/data follow the bus until the handshake captures,
    // then hold for the cycle in which they are consumed.
    always_ff @(posedge axi_clk) begin
        if (!wr_capture) begin
            waddr_p0 <= bus.axi_waddr;
            wdata_p0 <= bus.axi_din;
        end
        if (!rd_capture) raddr_p0 <= bus.axi_raddr;
    end

    // Stage p1 (write): register update, pulse and write count land with the ack.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            for (int k = 0; k < N_CTRL; k++) ctrl_q[k] <= CTRL_RST;
            scratch_q <= '0;
            wcnt_q    <= '0;
            pulse_out <= '0;
        end else begin
            pulse_out <= '0;
            if (wr_capture) begin
                wcnt_q <= wcnt_q + 32'd1;
                for (int k = 0; k < N_CTRL; k++) begin
                    if (waddr_p0 == 8'(int'(CTRL_BASE) + k)) ctrl_q[k] <= wdata_p0;
                end
                if (waddr_p0 == SCRATCH_ADDR) scratch_q <= wdata_p0;
                if (waddr_p0 == PULSE_ADDR)   pulse_out <= wdata_p0;
            end
        end
    end

    always_comb begin
        rd_mux = UNMAPPED_VAL;
        if (raddr_p0 == ID_ADDR)           rd_mux = BLOCK_ID;
        else if (raddr_p0 == SCRATCH_ADDR) rd_mux = scratch_q;
        else if (raddr_p0 == WCNT_ADDR)    rd_mux = wcnt_q;
        else if (raddr_p0 == RCNT_ADDR)    rd_mux = rcnt_q;
        else if (raddr_p0 == PULSE_ADDR)   rd_mux = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            if (raddr_p0 == 8'(int'(CTRL_BASE) + k)) rd_mux = ctrl_q[k];
        end
        for (int k = 0; k < N_STAT; k++) begin
            if (raddr_p0 == 8'(int'(STAT_BASE) + k)) rd_mux = stat_in[DATA_W*k +: DATA_W];
        end
    end

    // Stage p1 (read): mux sampled in the same edge as a concurrent write,
    // so a same-address read returns the pre-write value.
    always_ff @(posedge axi_clk) begin
        if (rd_capture) rd_data_p1 <= rd_mux;
    end

    // Stage p2 (read): data and ack presented together; rd_ack is vld_p1.
    always_ff @(posedge axi_clk) begin
        if (reset) begin
            bus.axi_rack <= 1'b0;
            bus.axi_dout <= '0;
            rcnt_q       <= '0;
        end else begin
            bus.axi_rack <= rd_ack;
            if (rd_ack) begin
                bus.axi_dout <= rd_data_p1;
                rcnt_q       <= rcnt_q + 32'd1;
            end
        end
    end

    for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl_out
        assign ctrl_out[DATA_W*k +: DATA_W] = ctrl_q[k];
    end

endmodule

// File: tb/tb_ldmx_reg_responder.sv
// Directed bench for ldmx_reg_responder with a read-data scoreboard queue.
module tb_ldmx_reg_responder;
    import ldmx_reg_pkg::*;

    localparam int N_CTRL = 8;
    localparam int N_STAT = 8;

    logic                     axi_clk = 1'b0;
    logic                     reset;
    logic [N_CTRL*32-1:0]     ctrl_out;
    logic [N_STAT*32-1:0]     stat_in;
    logic [31:0]              pulse_out;

    ldmx_reg_responder_if bus ();

    ldmx_reg_responder #(
        .N_CTRL   (N_CTRL),
        .N_STAT   (N_STAT),
        .CTRL_RST (32'h0),
        .BLOCK_ID (32'h4C444D58)
    ) dut (
        .axi_clk   (axi_clk),
        .reset     (reset),
        .bus       (bus.slave),
        .ctrl_out  (ctrl_out),
        .stat_in   (stat_in),
        .pulse_out (pulse_out)
    );

    always #5 axi_clk = ~axi_clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wr_done = 0;
    logic [31:0] rd_done = 0;
    logic [31:0] pulse_at_ack;
    logic [31:0] pulse_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, bus.axi_dout, e);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input int hold);
        bus.axi_wstr  = 1'b1;
        bus.axi_waddr = a;
        bus.axi_din   = d;
        for (int c = 0; c < hold; c++) begin
            tick();
            check(c == 1 ? "wack_n1" : "wack_quiet", {31'd0, bus.axi_wack}, (c == 1) ? 32'd1 : 32'd0);
            if (c == 1) pulse_at_ack = pulse_out;
        end
        bus.axi_wstr = 1'b0;
        tick();
        pulse_after = pulse_out;
        check("wack_after_drop", {31'd0, bus.axi_wack}, 32'd0);
        wr_done = wr_done + 32'd1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        bus.axi_rstr  = 1'b1;
        bus.axi_raddr = a;
        tick();
        check("rack_n0", {31'd0, bus.axi_rack}, 32'd0);
        tick();
        check("rack_n1", {31'd0, bus.axi_rack}, 32'd0);
        tick();
        check("rack_n2", {31'd0, bus.axi_rack}, 32'd1);
        pop_check(tag);
        rd_done = rd_done + 32'd1;
        bus.axi_rstr = 1'b0;
        tick();
        check("rack_one_cycle", {31'd0, bus.axi_rack}, 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.axi_wstr  = 1'b0;
        bus.axi_waddr = '0;
        bus.axi_din   = '0;
        bus.axi_rstr  = 1'b0;
        bus.axi_raddr = '0;
        for (int k = 0; k < N_STAT; k++) stat_in[32*k +: 32] = 32'h5000_0000 + 32'(k);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_wack", {31'd0, bus.axi_wack}, 32'd0);
        check("rst_rack", {31'd0, bus.axi_rack}, 32'd0);
        check("rst_dout", bus.axi_dout, 32'd0);
        check("rst_pulse", pulse_out, 32'd0);
        for (int k = 0; k < N_CTRL; k++) check("rst_ctrl", ctrl_out[32*k +: 32], 32'h0);

        do_read(8'hFF, 32'h4C444D58, "rd_id");
        do_read(8'h00, 32'h0, "rd_ctrl0_rst");

        do_write(8'h03, 32'hA5A5_0001, 5);
        check("ctrl3", ctrl_out[127:96], 32'hA5A5_0001);
        do_read(8'hFC, wr_done, "wcnt_single");

        do_write(8'h80, 32'h0000_0005, 2);
        check("pulse_n1", pulse_at_ack, 32'h5);
        check("pulse_n2", pulse_after, 32'h0);
        do_read(8'h80, 32'h0, "rd_pulse");

        // Simultaneous write and read to the same control word.
        exp_q.push_back(32'h0);
        bus.axi_wstr  = 1'b1;
        bus.axi_waddr = 8'h01;
        bus.axi_din   = 32'h1234;
        bus.axi_rstr  = 1'b1;
        bus.axi_raddr = 8'h01;
        tick();
        check("rw_wack_n0", {31'd0, bus.axi_wack}, 32'd0);
        tick();
        check("rw_wack_n1", {31'd0, bus.axi_wack}, 32'd1);
        check("rw_rack_n1", {31'd0, bus.axi_rack}, 32'd0);
        tick();
        check("rw_rack_n2", {31'd0, bus.axi_rack}, 32'd1);
        pop_check("rw_old_value");
        bus.axi_wstr = 1'b0;
        bus.axi_rstr = 1'b0;
        tick();
        wr_done = wr_done + 32'd1;
        rd_done = rd_done + 32'd1;
        do_read(8'h01, 32'h1234, "rw_new_value");

        do_read(8'h50, UNMAPPED_VAL, "rd_unmapped_stat");
        do_read(8'h43, 32'h5000_0003, "rd_stat3");
        do_write(8'h40, 32'h1, 2);
        do_read(8'h40, 32'h5000_0000, "rd_stat0_ro");
        do_write(8'hFE, 32'hCAFE_F00D, 2);
        do_read(8'hFE, 32'hCAFE_F00D, "rd_scratch");
        do_write(8'hFC, 32'h0, 2);
        do_read(8'hFC, wr_done, "wcnt_ro");
        do_read(8'hFD, rd_done, "rcnt");

        force dut.wcnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.wcnt_q;
        wr_done = 32'hFFFF_FFFF;
        do_read(8'hFC, wr_done, "wcnt_preload");
        do_write(8'h20, 32'h7777_7777, 2);
        do_read(8'hFC, wr_done, "wcnt_wrap");
        do_read(8'h20, UNMAPPED_VAL, "rd_unmapped_ctrl");

        // Reset lands in cycle N+1 of a read; strobe stays high through release.
        bus.axi_rstr  = 1'b1;
        bus.axi_raddr = 8'hFF;
        tick();
        check("abort_rack_n0", {31'd0, bus.axi_rack}, 32'd0);
        reset = 1'b1;
        tick();
        check("abort_rack_n1", {31'd0, bus.axi_rack}, 32'd0);
        check("abort_dout", bus.axi_dout, 32'd0);
        reset = 1'b0;
        tick();
        check("abort_rack_rel0", {31'd0, bus.axi_rack}, 32'd0);
        check("abort_dout_rel0", bus.axi_dout, 32'd0);
        tick();
        check("abort_rack_rel1", {31'd0, bus.axi_rack}, 32'd0);
        tick();
        check("abort_rack_rel2", {31'd0, bus.axi_rack}, 32'd1);
        check("abort_dout_id", bus.axi_dout, 32'h4C444D58);
        bus.axi_rstr = 1'b0;
        tick();
        check("abort_rack_drop", {31'd0, bus.axi_rack}, 32'd0);
        wr_done = 32'd0;
        rd_done = 32'd1;
        check("ctrl3_after_reset", ctrl_out[127:96], 32'h0);
        do_read(8'h03, 32'h0, "rd_ctrl3_reset");
        do_read(8'hFC, wr_done, "wcnt_after_reset");
        do_read(8'hFD, rd_done, "rcnt_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
